// File: rtl/ps2_device_emulator.sv
// Device side of a PS/2 link: drives PS2_CLK, shifts bytes out to the host and
// receives host commands (request-to-send) with an ACK pulse.
module ps2_device_emulator #(
    parameter int HALF_PERIOD  = 1500,
    parameter int IDLE_WAIT    = 2500,
    parameter int RTS_DEBOUNCE = 250
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_aborted,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_error,
    output logic       rx_frame_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int PW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int IW_W = $clog2(IDLE_WAIT + 1);
    localparam int RW   = (RTS_DEBOUNCE > 1) ? $clog2(RTS_DEBOUNCE) : 1;
    localparam logic [PW-1:0]   PH_LAST   = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0]   PH_SETTLE = PW'(HALF_PERIOD - 4);
    localparam logic [IW_W-1:0] IDLE_MAX  = IW_W'(IDLE_WAIT);
    localparam logic [RW-1:0]   RTS_LAST  = RW'(RTS_DEBOUNCE - 1);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_ACK} state_t;

    state_t          state_q, state_d;
    logic            phase_low_q, phase_low_d;
    logic [PW-1:0]   phase_cnt_q, phase_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [IW_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [RW-1:0]   rts_cnt_q, rts_cnt_d;
    logic [9:0]      tx_sh_q, tx_sh_d;
    logic [8:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic            tx_done_q, tx_done_d, tx_aborted_q, tx_aborted_d;
    logic            rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
    logic            clk_m_q, clk_s_q, dat_m_q, dat_s_q;
    logic            phase_end, inhibit;

    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    assign tx_ready        = (state_q == S_IDLE) && (idle_cnt_q == IDLE_MAX) && (rts_cnt_q == '0);
    assign tx_done         = tx_done_q;
    assign tx_aborted      = tx_aborted_q;
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign rx_parity_error = rx_perr_q;
    assign rx_frame_error  = rx_ferr_q;

    // Host pulling the clock low counts only once our release has had time to cross the synchroniser.
    assign phase_end = (phase_cnt_q == '0);
    assign inhibit   = !phase_low_q && (phase_cnt_q <= PH_SETTLE) && !clk_s_q;

    always_comb begin
        state_d      = state_q;
        phase_low_d  = phase_low_q;
        phase_cnt_d  = phase_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = '0;
        rts_cnt_d    = '0;
        tx_sh_d      = tx_sh_q;
        rx_sh_d      = rx_sh_q;
        rx_data_d    = rx_data_q;
        clk_oe_d     = clk_oe_q;
        dat_oe_d     = dat_oe_q;
        tx_done_d    = 1'b0;
        tx_aborted_d = 1'b0;
        rx_valid_d   = 1'b0;
        rx_perr_d    = 1'b0;
        rx_ferr_d    = 1'b0;
        if (state_q != S_IDLE && !phase_end) phase_cnt_d = phase_cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (clk_s_q && dat_s_q)
                    idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
                if (clk_s_q && !dat_s_q) rts_cnt_d = rts_cnt_q + 1'b1;
                if (clk_s_q && !dat_s_q && rts_cnt_q == RTS_LAST) begin
                    state_d     = S_RX;
                    phase_low_d = 1'b1;
                    phase_cnt_d = PH_LAST;
                    bit_cnt_d   = 4'd0;
                    clk_oe_d    = 1'b1;
                    rts_cnt_d   = '0;
                end else if (tx_valid && tx_ready) begin
                    // Start bit is presented immediately; the rest waits in the shifter.
                    tx_sh_d     = {1'b1, ~^tx_data, tx_data};
                    state_d     = S_TX;
                    phase_low_d = 1'b0;
                    phase_cnt_d = PH_LAST;
                    bit_cnt_d   = 4'd0;
                    dat_oe_d    = 1'b1;
                end
            end
            S_TX: begin
                if (inhibit) begin
                    state_d      = S_IDLE;
                    clk_oe_d     = 1'b0;
                    dat_oe_d     = 1'b0;
                    tx_aborted_d = 1'b1;
                end else if (phase_end) begin
                    if (!phase_low_q) begin
                        if (bit_cnt_q == 4'd11) begin
                            tx_done_d = 1'b1;
                            state_d   = S_IDLE;
                            dat_oe_d  = 1'b0;
                        end else begin
                            phase_low_d = 1'b1;
                            clk_oe_d    = 1'b1;
                            phase_cnt_d = PH_LAST;
                        end
                    end else begin
                        phase_low_d = 1'b0;
                        clk_oe_d    = 1'b0;
                        phase_cnt_d = PH_LAST;
                        dat_oe_d    = ~tx_sh_q[0];
                        tx_sh_d     = {1'b1, tx_sh_q[9:1]};
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_RX: begin
                if (inhibit) begin
                    state_d  = S_IDLE;
                    clk_oe_d = 1'b0;
                end else if (phase_end) begin
                    if (phase_low_q) begin
                        phase_low_d = 1'b0;
                        clk_oe_d    = 1'b0;
                        phase_cnt_d = PH_LAST;
                    end else if (bit_cnt_q == 4'd9) begin
                        if (!dat_s_q) begin
                            rx_ferr_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d     = S_ACK;
                            phase_low_d = 1'b1;
                            clk_oe_d    = 1'b1;
                            dat_oe_d    = 1'b1;
                            phase_cnt_d = PH_LAST;
                        end
                    end else begin
                        rx_sh_d     = {dat_s_q, rx_sh_q[8:1]};
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        phase_low_d = 1'b1;
                        clk_oe_d    = 1'b1;
                        phase_cnt_d = PH_LAST;
                    end
                end
            end
            S_ACK: begin
                if (phase_end) begin
                    if (phase_low_q) begin
                        phase_low_d = 1'b0;
                        clk_oe_d    = 1'b0;
                        phase_cnt_d = PH_LAST;
                    end else begin
                        rx_data_d  = rx_sh_q[7:0];
                        rx_valid_d = 1'b1;
                        rx_perr_d  = ~^rx_sh_q;
                        dat_oe_d   = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_low_q  <= 1'b0;
            phase_cnt_q  <= '0;
            bit_cnt_q    <= 4'd0;
            idle_cnt_q   <= '0;
            rts_cnt_q    <= '0;
            rx_data_q    <= 8'h00;
            clk_oe_q     <= 1'b0;
            dat_oe_q     <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_aborted_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            clk_m_q      <= 1'b1;
            clk_s_q      <= 1'b1;
            dat_m_q      <= 1'b1;
            dat_s_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_low_q  <= phase_low_d;
            phase_cnt_q  <= phase_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            rts_cnt_q    <= rts_cnt_d;
            rx_data_q    <= rx_data_d;
            clk_oe_q     <= clk_oe_d;
            dat_oe_q     <= dat_oe_d;
            tx_done_q    <= tx_done_d;
            tx_aborted_q <= tx_aborted_d;
            rx_valid_q   <= rx_valid_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
            clk_m_q      <= PS2_CLK;
            clk_s_q      <= clk_m_q;
            dat_m_q      <= PS2_DAT;
            dat_s_q      <= dat_m_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= rx_sh_d;
    end

endmodule

// File: tb/tb_ps2_device_emulator.sv
// Directed bench for ps2_device_emulator with a pulled-up open-drain host model.
module tb_ps2_device_emulator;
    localparam int HP = 50;
    localparam int IW = 100;
    localparam int RD = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_aborted, rx_valid, rx_parity_error, rx_frame_error;
    logic [7:0] rx_data;
    wire        ps2_clk, ps2_dat;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

    ps2_device_emulator #(.HALF_PERIOD(HP), .IDLE_WAIT(IW), .RTS_DEBOUNCE(RD)) dut (
        .CLOCK_50(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_aborted(tx_aborted),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_error(rx_parity_error),
        .rx_frame_error(rx_frame_error), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_abort = 0, n_rxv = 0, n_ferr = 0, n_neg = 0, n_ack = 0;
    logic        last_perr = 1'b0;
    logic [31:0] mon_sh = 32'h0;

    always @(posedge clk) begin
        if (tx_done)        n_done  <= n_done + 1;
        if (tx_aborted)     n_abort <= n_abort + 1;
        if (rx_valid)       n_rxv   <= n_rxv + 1;
        if (rx_frame_error) n_ferr  <= n_ferr + 1;
        if (rx_valid)       last_perr <= rx_parity_error;
    end

    // Host view of each PS2_CLK falling edge: data bit seen, and whether the device pulled data low.
    always @(negedge ps2_clk) begin
        #1;
        n_neg  = n_neg + 1;
        mon_sh = {ps2_dat, mon_sh[31:1]};
        if (!host_dat_low && !ps2_dat) n_ack = n_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if (n_neg >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if (tx_ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Host request-to-send: data low with clock released, then one bit per device falling edge.
    task automatic host_cmd(input logic [7:0] b, input bit par, input bit stop, input bit race);
        logic [9:0] fr;
        int  base, rb, fb;
        bit  ok, all_ok, seen_ready;
        fr = {stop, par, b};
        base = n_neg; rb = n_rxv; fb = n_ferr;
        seen_ready = 1'b0;
        all_ok = 1'b0;
        @(negedge clk);
        host_dat_low = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (race && c == 3) begin tx_data = 8'h77; tx_valid = 1'b1; end
            if (race && c >= 3 && tx_ready) seen_ready = 1'b1;
            if (n_neg > base) begin all_ok = 1'b1; break; end
        end
        if (race) chk("race_tx_ready", {31'd0, seen_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            wait_neg(base + i + 1, 300, ok);
            all_ok = all_ok & ok;
            host_dat_low = !fr[i];
        end
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (n_rxv != rb || n_ferr != fb) begin ok = 1'b1; break; end
        end
        host_dat_low = 1'b0;
        tx_valid = 1'b0;
        chk("rx_handshake_timeout", {31'd0, all_ok & ok}, 32'd1);
        repeat (10) @(posedge clk);
    endtask

    initial begin
        int  lat, b_neg, b_done, b_abort, b_rxv, b_ferr, b_ack;
        bit  ok, seen;

        repeat (3) @(posedge clk); #1;
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_pulses", {28'd0, tx_done, tx_aborted, rx_valid, rx_frame_error}, 32'd0);
        chk("rst_perr", {31'd0, rx_parity_error}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        @(negedge clk) reset = 1'b0;

        lat = 0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (tx_ready) begin ok = 1'b1; break; end
            lat++;
        end
        chk("ready_after_idle", {31'd0, ok && (lat >= IW - 1)}, 32'd1);

        // 8'h1C: start 0, data LSB first 0,0,1,1,1,0,0,0, parity 0, stop 1
        b_neg = n_neg; b_abort = n_abort;
        send(8'h1C);
        ok = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (tx_done) begin ok = 1'b1; break; end
        end
        chk("tx_done_seen", {31'd0, ok}, 32'd1);
        chk("tx_edges", n_neg - b_neg, 32'd11);
        chk("tx_frame_1c", {21'd0, mon_sh[31:21]}, 32'b10000111000);
        chk("tx_no_abort", n_abort - b_abort, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < IW - 1; c++) begin
            @(posedge clk); #1;
            if (tx_ready) seen = 1'b1;
        end
        chk("ready_low_after_done", {31'd0, seen | tx_ready}, 32'd0);
        wait_ready(5, ok);
        chk("ready_returns", {31'd0, ok}, 32'd1);

        // Inhibit during the H phase of bit 4 (d3 of 8'h55 = 0, so data is being driven low)
        b_neg = n_neg; b_abort = n_abort; b_done = n_done;
        send(8'h55);
        wait_neg(b_neg + 4, 1000, ok);
        for (int c = 0; c < 100 && ps2_clk !== 1'b1; c++) @(posedge clk);
        repeat (10) @(posedge clk);
        host_clk_low = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (tx_aborted) begin seen = 1'b1; break; end
        end
        chk("abort_pulse", {31'd0, ok & seen}, 32'd1);
        @(posedge clk); #1;
        chk("abort_dat_released", {31'd0, ps2_dat}, 32'd1);
        repeat (5) @(posedge clk);
        host_clk_low = 1'b0;
        repeat (200) @(posedge clk); #1;
        chk("abort_once", n_abort - b_abort, 32'd1);
        chk("abort_no_done", n_done - b_done, 32'd0);
        chk("abort_lines_idle", {30'd0, ps2_clk, ps2_dat}, 32'd3);

        // 8'hF4 has five ones, so parity 0 is correct
        b_rxv = n_rxv; b_ack = n_ack; b_ferr = n_ferr;
        host_cmd(8'hF4, 1'b0, 1'b1, 1'b0);
        chk("rx_f4_valid", n_rxv - b_rxv, 32'd1);
        chk("rx_f4_data", {24'd0, rx_data}, 32'hF4);
        chk("rx_f4_perr", {31'd0, last_perr}, 32'd0);
        chk("rx_f4_ack", n_ack - b_ack, 32'd1);
        chk("rx_f4_no_ferr", n_ferr - b_ferr, 32'd0);

        // 8'hED has six ones, so parity 0 is the wrong odd-parity bit
        b_rxv = n_rxv; b_ack = n_ack;
        host_cmd(8'hED, 1'b0, 1'b1, 1'b0);
        chk("rx_ed_valid", n_rxv - b_rxv, 32'd1);
        chk("rx_ed_data", {24'd0, rx_data}, 32'hED);
        chk("rx_ed_perr", {31'd0, last_perr}, 32'd1);
        chk("rx_ed_ack", n_ack - b_ack, 32'd1);

        b_rxv = n_rxv; b_ack = n_ack; b_ferr = n_ferr;
        host_cmd(8'h3C, 1'b1, 1'b0, 1'b0);
        chk("ferr_pulse", n_ferr - b_ferr, 32'd1);
        chk("ferr_no_valid", n_rxv - b_rxv, 32'd0);
        chk("ferr_no_ack", n_ack - b_ack, 32'd0);
        chk("ferr_data_kept", {24'd0, rx_data}, 32'hED);

        // tx_valid raised while an RTS is being debounced
        wait_ready(300, ok);
        chk("race_ready_before", {31'd0, ok}, 32'd1);
        b_rxv = n_rxv; b_done = n_done; b_neg = n_neg;
        host_cmd(8'hAA, 1'b1, 1'b1, 1'b1);
        repeat (50) @(posedge clk); #1;
        chk("race_rx_data", {24'd0, rx_data}, 32'hAA);
        chk("race_rx_valid", n_rxv - b_rxv, 32'd1);
        chk("race_no_tx", n_done - b_done, 32'd0);
        chk("race_edges", n_neg - b_neg, 32'd11);

        // Reset during the L phase of bit 2 (d1 of 8'h55 = 0): both lines held low by the device
        wait_ready(300, ok);
        b_neg = n_neg;
        send(8'h55);
        wait_neg(b_neg + 3, 1000, ok);
        chk("mid_tx_lines_low", {30'd0, ps2_clk, ps2_dat}, {30'd0, 2'b00});
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        chk("mid_rst_outputs", {26'd0, tx_ready, tx_done, tx_aborted, rx_valid, rx_parity_error, rx_frame_error}, 32'd0);
        chk("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
        b_done = n_done; b_abort = n_abort;
        @(negedge clk) reset = 1'b0;
        repeat (200) @(posedge clk); #1;
        chk("mid_rst_no_pulse", (n_done - b_done) + (n_abort - b_abort), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
